demux_byte_collector: RTL and testbench
=======================================

DEMUX_BYTE_COLLECTOR -- requirements
Module: demux_byte_collector

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bits per assembled word per channel (legal values 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: d1  input  1  serial bit from the 1x2 demux output o1 (a AND s).
REQ-005 SHALL have port: d2  input  1  serial bit from the 1x2 demux output o2 (a AND NOT s).
REQ-006 SHALL have port: sel  input  1  copy of the demux select s; 1 = channel 1 active, 0 = channel 2 active.
REQ-007 SHALL have port: bit_valid  input  1  qualifies d1/d2/sel for one cycle.
REQ-008 SHALL have ports: ready1, ready2  input  1 each  consumer accepts word on channel 1/2.
REQ-009 SHALL have ports: word1, word2  output  WIDTH each  assembled word per channel.
REQ-010 SHALL have ports: valid1, valid2  output  1 each  word1/word2 holds an unconsumed word.
REQ-011 SHALL have ports: ovf1, ovf2  output  1 each  sticky overflow flag per channel.
REQ-012 SHALL have port: ovf_clr  input  1  clears both overflow flags.

Function
REQ-013 SHALL accept a bit for channel 1 on an edge where bit_valid=1 and sel=1, value d1; for channel 2 where bit_valid=1 and sel=0, value d2.
REQ-014 SHALL ignore d2 when sel=1, d1 when sel=0, and all inputs when bit_valid=0 (no state change beyond handshake).
REQ-015 SHALL assemble LSB-first: first accepted bit of a word ends in bit 0, WIDTH-th accepted bit in bit WIDTH-1.
REQ-016 SHALL keep per-channel bit counter 0..WIDTH-1; increments per accepted bit; wraps to 0 on WIDTH-th bit.
REQ-017 SHALL, on the edge accepting the WIDTH-th bit, load the complete word into the holding register and set valid; valid visible the following cycle (latency 1 clock after last bit).
REQ-018 SHALL hold wordN and validN stable while validN=1 and readyN=0.
REQ-019 SHALL transfer on an edge with validN=1 and readyN=1; validN clears next cycle unless REQ-020 applies.
REQ-020 SHALL, if a word completes on the same edge as a transfer, load the new word and keep validN=1 (no bubble, no overflow).
REQ-021 SHALL, if a word completes while validN=1 and readyN=0, drop the new word, keep holding register unchanged, set ovfN=1; bit counter still wraps to 0.
REQ-022 SHALL keep ovfN set until ovf_clr=1 or rst; if ovf_clr and a new overflow occur on the same edge, ovfN SHALL end at 1.
REQ-023 SHALL operate both channels fully independently; interleaved bits on sel SHALL NOT disturb the other channel's partial word.
REQ-024 readyN while validN=0 SHALL have no effect.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, clear both bit counters, shift registers, word1/word2 (0), valid1/valid2 (0), ovf1/ovf2 (0).
REQ-026 SHALL discard any partial word on reset mid-byte; rst SHALL take priority over all other inputs that edge.

Structure
REQ-027 SHALL place WIDTH default and counter width ($clog2 of WIDTH) in a shared package demux_pkg.
REQ-028 SHALL implement one sub-module collector_channel (counter, shift register, holding register, handshake, overflow), instantiated twice.
REQ-029 Top level SHALL contain only per-channel bit/enable steering and instantiation; no flip-flops outside collector_channel.

Verification
REQ-030 WIDTH=8, sel=1, bits 1,0,1,0,0,1,0,1 on d1 in 8 consecutive cycles, ready1=1 -> word1=0xA5, valid1=1 exactly one cycle, channel 2 idle.
REQ-031 Interleave ch1 byte 0x3C and ch2 byte 0xC3 bit-by-bit alternating sel -> word1=0x3C, word2=0xC3, both valid after their 8th bit.
REQ-032 ready1=0, send 0x11 then 0x22 on ch1 -> word1 stays 0x11, ovf1=1 after 0x22's 8th bit; ovf_clr pulse -> ovf1=0.
REQ-033 ready1 rises on same edge as 8th bit of second word -> first word transferred, word1=second word, valid1 stays 1, ovf1=0.
REQ-034 rst pulse after 4 bits on ch2, then 8 bits 0xFF -> word2=0xFF (no residue), all flags 0 directly after reset.
REQ-035 bit_valid=0 with toggling d1/d2/sel for 20 cycles -> no counter change, valid1=valid2=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux byte collector and its channels.
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);
  localparam int NUM_CH    = 2;

  // Counter width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/collector_channel.sv
// One serial-to-parallel channel: bit counter, shift register, holding register
// with valid/ready handshake and a sticky overflow flag.
module collector_channel
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic             ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             xfer;
  logic             ovf_set;

  always_comb begin
    // New bits enter at the MSB so the first bit ends up in bit 0.
    shifted  = {bit_in, shreg_q[WIDTH-1:1]};
    complete = bit_en && (cnt_q == CNT_LAST);
    xfer     = valid_q && ready;
    ovf_set  = 1'b0;

    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;

    if (bit_en) begin
      shreg_d = shifted;
      cnt_d   = complete ? '0 : cnt_q + 1'b1;
    end

    if (xfer) valid_d = 1'b0;

    // A finished word may load whenever the holder is empty or draining now.
    if (complete) begin
      if (!valid_q || ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end

    ovf_d = (ovf_q && !ovf_clr) || ovf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word  = word_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/demux_byte_collector.sv
// Collects the two serial outputs of a 1x2 demux into per-channel words.
// Only steering lives here; all state is inside collector_channel.
module demux_byte_collector
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d1,
  input  logic             d2,
  input  logic             sel,
  input  logic             bit_valid,
  input  logic             ready1,
  input  logic             ready2,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] word1,
  output logic [WIDTH-1:0] word2,
  output logic             valid1,
  output logic             valid2,
  output logic             ovf1,
  output logic             ovf2
);

  logic [NUM_CH-1:0]            bit_en;
  logic [NUM_CH-1:0]            bit_in;
  logic [NUM_CH-1:0]            ready;
  logic [NUM_CH-1:0]            valid;
  logic [NUM_CH-1:0]            ovf;
  logic [NUM_CH-1:0][WIDTH-1:0] word;

  // Lane 0 is channel 1 (sel=1), lane 1 is channel 2 (sel=0).
  assign bit_en = {bit_valid && !sel, bit_valid && sel};
  assign bit_in = {d2, d1};
  assign ready  = {ready2, ready1};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      collector_channel #(.WIDTH(WIDTH)) u_ch (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en[g]),
        .bit_in  (bit_in[g]),
        .ready   (ready[g]),
        .ovf_clr (ovf_clr),
        .word    (word[g]),
        .valid   (valid[g]),
        .ovf     (ovf[g])
      );
    end
  endgenerate

  assign word1  = word[0];
  assign word2  = word[1];
  assign valid1 = valid[0];
  assign valid2 = valid[1];
  assign ovf1   = ovf[0];
  assign ovf2   = ovf[1];

endmodule

// File: tb/tb_demux_byte_collector.sv
// Scenario bench for demux_byte_collector: expected words are queued when the
// last bit is driven and popped when the channel raises valid.
module tb_demux_byte_collector;

  logic       clk = 1'b0;
  logic       rst, d1, d2, sel, bit_valid, ready1, ready2, ovf_clr;
  logic [7:0] word1, word2;
  logic       valid1, valid2, ovf1, ovf2;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [7:0] exp1_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] exp;

  always #5 clk = ~clk;

  demux_byte_collector #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .sel(sel), .bit_valid(bit_valid),
    .ready1(ready1), .ready2(ready2), .ovf_clr(ovf_clr),
    .word1(word1), .word2(word2), .valid1(valid1), .valid2(valid2),
    .ovf1(ovf1), .ovf2(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted bit; the idle channel's data line carries noise.
  task automatic send_bit(input int ch, input logic b);
    bit_valid = 1'b1;
    sel       = (ch == 1);
    if (ch == 1) begin
      d1 = b; d2 = 1'($urandom_range(0, 1));
    end else begin
      d2 = b; d1 = 1'($urandom_range(0, 1));
    end
    tick();
    bit_valid = 1'b0;
    d1 = 1'b0; d2 = 1'b0;
  endtask

  task automatic send_bits(input int ch, input logic [7:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(ch, v[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_chk++; if ({word1, word2} !== 16'h0) $display("FAIL reset_words: got %h required 0000", {word1, word2}); else n_pass++;
    n_chk++; if ({valid1, valid2} !== 2'b00) $display("FAIL reset_valid: got %b required 00", {valid1, valid2}); else n_pass++;
    n_chk++; if ({ovf1, ovf2} !== 2'b00) $display("FAIL reset_ovf: got %b required 00", {ovf1, ovf2}); else n_pass++;
  endtask

  task automatic test_single();
    ready1 = 1'b1;
    send_bits(1, 8'hA5, 0, 6);
    n_chk++; if (valid1 !== 1'b0) $display("FAIL single_early: valid1 got %b required 0", valid1); else n_pass++;
    exp1_q.push_back(8'hA5);
    send_bit(1, 1'b1);
    n_chk++; if (valid1 !== 1'b1) $display("FAIL single_valid: got %b required 1", valid1); else n_pass++;
    exp = exp1_q.pop_front();
    n_chk++; if (word1 !== exp) $display("FAIL single_word: got %h required %h", word1, exp); else n_pass++;
    tick();
    n_chk++; if (valid1 !== 1'b0) $display("FAIL single_one_cycle: valid1 got %b required 0", valid1); else n_pass++;
    n_chk++; if ({valid2, word2} !== 9'h0) $display("FAIL single_ch2_idle: got %b/%h required 0/00", valid2, word2); else n_pass++;
    ready1 = 1'b0;
  endtask

  task automatic test_interleave();
    logic [7:0] a, b;
    a = 8'h3C; b = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp1_q.push_back(a);
      send_bit(1, a[i]);
      if (i == 7) begin
        n_chk++; if (valid1 !== 1'b1) $display("FAIL ilv_valid1: got %b required 1", valid1); else n_pass++;
        exp = exp1_q.pop_front();
        n_chk++; if (word1 !== exp) $display("FAIL ilv_word1: got %h required %h", word1, exp); else n_pass++;
      end
      if (i == 7) exp2_q.push_back(b);
      send_bit(2, b[i]);
    end
    n_chk++; if (valid2 !== 1'b1) $display("FAIL ilv_valid2: got %b required 1", valid2); else n_pass++;
    exp = exp2_q.pop_front();
    n_chk++; if (word2 !== exp) $display("FAIL ilv_word2: got %h required %h", word2, exp); else n_pass++;
    n_chk++; if (word1 !== 8'h3C) $display("FAIL ilv_word1_hold: got %h required 3c", word1); else n_pass++;
    ready1 = 1'b1; ready2 = 1'b1; tick(); ready1 = 1'b0; ready2 = 1'b0;
    n_chk++; if ({valid1, valid2} !== 2'b00) $display("FAIL ilv_drain: got %b required 00", {valid1, valid2}); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] held;
    exp1_q.push_back(8'h11);
    send_bits(1, 8'h11, 0, 7);
    exp = exp1_q.pop_front();
    n_chk++; if (valid1 !== 1'b1 || word1 !== exp) $display("FAIL ovf_first: got %b/%h required 1/%h", valid1, word1, exp); else n_pass++;
    held = exp;
    send_bits(1, 8'h22, 0, 7);
    n_chk++; if (word1 !== held || valid1 !== 1'b1) $display("FAIL ovf_hold: got %b/%h required 1/%h", valid1, word1, held); else n_pass++;
    n_chk++; if (ovf1 !== 1'b1 || ovf2 !== 1'b0) $display("FAIL ovf_set: got %b%b required 10", ovf1, ovf2); else n_pass++;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_chk++; if (ovf1 !== 1'b0) $display("FAIL ovf_clr: got %b required 0", ovf1); else n_pass++;
    // Clear and new overflow on the same edge: the new overflow wins.
    send_bits(1, 8'h33, 0, 6);
    ovf_clr = 1'b1;
    send_bit(1, 1'b0);
    ovf_clr = 1'b0;
    n_chk++; if (ovf1 !== 1'b1 || word1 !== held) $display("FAIL ovf_clr_race: got %b/%h required 1/%h", ovf1, word1, held); else n_pass++;
    ovf_clr = 1'b1; ready1 = 1'b1; tick(); ovf_clr = 1'b0; ready1 = 1'b0;
    n_chk++; if ({valid1, ovf1} !== 2'b00) $display("FAIL ovf_drain: got %b required 00", {valid1, ovf1}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp1_q.push_back(8'h5A);
    send_bits(1, 8'h5A, 0, 7);
    exp = exp1_q.pop_front();
    n_chk++; if (valid1 !== 1'b1 || word1 !== exp) $display("FAIL b2b_first: got %b/%h required 1/%h", valid1, word1, exp); else n_pass++;
    send_bits(1, 8'h96, 0, 6);
    exp1_q.push_back(8'h96);
    ready1 = 1'b1;
    send_bit(1, 1'b1);
    exp = exp1_q.pop_front();
    n_chk++; if (valid1 !== 1'b1 || word1 !== exp) $display("FAIL b2b_second: got %b/%h required 1/%h", valid1, word1, exp); else n_pass++;
    n_chk++; if (ovf1 !== 1'b0) $display("FAIL b2b_no_ovf: got %b required 0", ovf1); else n_pass++;
    tick(); ready1 = 1'b0;
    n_chk++; if (valid1 !== 1'b0) $display("FAIL b2b_drain: got %b required 0", valid1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send_bits(2, 8'h0A, 0, 3);
    rst = 1'b1; bit_valid = 1'b1; sel = 1'b0; d2 = 1'b1;
    tick();
    rst = 1'b0; bit_valid = 1'b0; d2 = 1'b0;
    n_chk++; if ({valid1, valid2, ovf1, ovf2} !== 4'b0) $display("FAIL rstmid_flags: got %b required 0000", {valid1, valid2, ovf1, ovf2}); else n_pass++;
    n_chk++; if ({word1, word2} !== 16'h0) $display("FAIL rstmid_words: got %h required 0000", {word1, word2}); else n_pass++;
    send_bits(2, 8'hFF, 0, 6);
    n_chk++; if (valid2 !== 1'b0) $display("FAIL rstmid_residue: valid2 got %b required 0", valid2); else n_pass++;
    exp2_q.push_back(8'hFF);
    send_bit(2, 1'b1);
    exp = exp2_q.pop_front();
    n_chk++; if (valid2 !== 1'b1 || word2 !== exp) $display("FAIL rstmid_word: got %b/%h required 1/%h", valid2, word2, exp); else n_pass++;
    ready2 = 1'b1; tick(); ready2 = 1'b0;
  endtask

  task automatic test_idle();
    int unsigned bad = 0;
    bit_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d1  = 1'($urandom_range(0, 1));
      d2  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      tick();
      if ({valid1, valid2} !== 2'b00) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL idle_valid: %0d cycles with valid set, required 0", bad); else n_pass++;
    send_bits(1, 8'h3C, 0, 6);
    n_chk++; if (valid1 !== 1'b0) $display("FAIL idle_cnt: valid1 got %b required 0", valid1); else n_pass++;
    exp1_q.push_back(8'h3C);
    send_bit(1, 1'b0);
    exp = exp1_q.pop_front();
    n_chk++; if (valid1 !== 1'b1 || word1 !== exp) $display("FAIL idle_word: got %b/%h required 1/%h", valid1, word1, exp); else n_pass++;
  endtask

  initial begin
    rst = 1'b0; d1 = 1'b0; d2 = 1'b0; sel = 1'b0; bit_valid = 1'b0;
    ready1 = 1'b0; ready2 = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_interleave();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
